// File: rtl/exec_sequencer.sv
// Execution sequencer: sweeps a host-selected BRAM address window [base, base+len),
// issuing reads and writing each ALU result back to the address it was read from.
module exec_sequencer #(
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LAT     = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  input  logic                  abort_i,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic                  sel_mem_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  aborted_o,
  output logic [ADDR_WIDTH:0]   count_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [ADDR_WIDTH:0] CNT_ZERO   = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0] CNT_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [2:0]          DRAIN_LAST = 3'(RD_LAT - 1);

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [ADDR_WIDTH:0]     len_q;
  logic [ADDR_WIDTH:0]     issued_q;
  logic [2:0]              drain_q;
  logic                    rd_en_q;
  logic [ADDR_WIDTH-1:0]   rd_addr_q;
  logic                    done_q;
  logic                    aborted_q;
  logic [ADDR_WIDTH:0]     count_q;
  logic [RD_LAT-1:0]       pipe_v_q;
  logic [ADDR_WIDTH-1:0]   pipe_a_q [RD_LAT];

  logic [ADDR_WIDTH:0]     issued_inc;
  logic [ADDR_WIDTH-1:0]   next_addr;
  logic                    run_abort;
  logic                    start_acc;

  // Next read address and the qualified abort/start strobes.
  always_comb begin
    issued_inc = issued_q + CNT_ONE;
    next_addr  = base_q + issued_inc[ADDR_WIDTH-1:0];
    run_abort  = 1'b0;
    start_acc  = 1'b0;
    if ((state_q == S_ISSUE) || (state_q == S_DRAIN)) begin
      run_abort = abort_i;
    end else begin
      run_abort = 1'b0;
    end
    if (state_q == S_IDLE) begin
      start_acc = start_i;
    end else begin
      start_acc = 1'b0;
    end
  end

  // Control FSM with registered read port, done/aborted flags and result counter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      base_q    <= {ADDR_WIDTH{1'b0}};
      len_q     <= CNT_ZERO;
      issued_q  <= CNT_ZERO;
      drain_q   <= 3'd0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= {ADDR_WIDTH{1'b0}};
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      count_q   <= CNT_ZERO;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            base_q    <= base_addr_i;
            len_q     <= len_i;
            issued_q  <= CNT_ZERO;
            drain_q   <= 3'd0;
            rd_addr_q <= base_addr_i;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            if (len_i != CNT_ZERO) begin
              state_q <= S_ISSUE;
              rd_en_q <= 1'b1;
            end else begin
              // Empty window: done_o follows one cycle later, from DONE itself.
              state_q <= S_DONE;
              rd_en_q <= 1'b0;
            end
          end else begin
            rd_en_q <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (abort_i) begin
            state_q   <= S_DONE;
            rd_en_q   <= 1'b0;
            done_q    <= 1'b1;
            aborted_q <= 1'b1;
          end else if (issued_q == (len_q - CNT_ONE)) begin
            state_q <= S_DRAIN;
            rd_en_q <= 1'b0;
          end else begin
            issued_q  <= issued_inc;
            rd_addr_q <= next_addr;
          end
        end
        S_DRAIN: begin
          rd_en_q <= 1'b0;
          if (abort_i) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            aborted_q <= 1'b1;
          end else if (drain_q == DRAIN_LAST) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + 3'd1;
          end
        end
        S_DONE: begin
          rd_en_q <= 1'b0;
          // Leave only once done_o has been visible, so the host always sees it.
          if (!start_i && done_q) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end else begin
            done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          rd_en_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase

      if (start_acc) begin
        count_q <= CNT_ZERO;
      end else if (wr_en_o) begin
        count_q <= count_q + CNT_ONE;
      end else begin
        count_q <= count_q;
      end
    end
  end

  // Read-latency valid pipeline; its tail drives the result-BRAM write port.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pipe_v_q <= {RD_LAT{1'b0}};
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_a_q[i] <= {ADDR_WIDTH{1'b0}};
      end
    end else if (run_abort) begin
      pipe_v_q <= {RD_LAT{1'b0}};
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_a_q[i] <= {ADDR_WIDTH{1'b0}};
      end
    end else begin
      pipe_v_q[0] <= rd_en_q;
      pipe_a_q[0] <= rd_addr_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v_q[i] <= pipe_v_q[i-1];
        pipe_a_q[i] <= pipe_a_q[i-1];
      end
    end
  end

  assign rd_en_o   = rd_en_q;
  assign rd_addr_o = rd_addr_q;
  assign wr_en_o   = pipe_v_q[RD_LAT-1];
  assign wr_addr_o = pipe_a_q[RD_LAT-1];
  assign busy_o    = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign sel_mem_o = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done_o    = done_q;
  assign aborted_o = aborted_q;
  assign count_o   = count_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: table-driven vectors on an RD_LAT=1 instance,
// hand-written abort/reset sequences, and a full sweep on an RD_LAT=3 instance.
module tb_exec_sequencer;

  logic CLK;
  logic RST;

  logic        s1, ab1;
  logic [9:0]  base1;
  logic [10:0] len1;
  logic        d1_rd_en, d1_wr_en, d1_sel, d1_busy, d1_done, d1_aborted;
  logic [9:0]  d1_rd_addr, d1_wr_addr;
  logic [10:0] d1_count;

  logic        s3, ab3;
  logic [9:0]  base3;
  logic [10:0] len3;
  logic        d3_rd_en, d3_wr_en, d3_sel, d3_busy, d3_done, d3_aborted;
  logic [9:0]  d3_rd_addr, d3_wr_addr;
  logic [10:0] d3_count;

  exec_sequencer #(.ADDR_WIDTH(10), .RD_LAT(1)) dut1 (
    .CLK(CLK), .RST(RST), .start_i(s1), .base_addr_i(base1), .len_i(len1), .abort_i(ab1),
    .rd_en_o(d1_rd_en), .rd_addr_o(d1_rd_addr), .wr_en_o(d1_wr_en), .wr_addr_o(d1_wr_addr),
    .sel_mem_o(d1_sel), .busy_o(d1_busy), .done_o(d1_done), .aborted_o(d1_aborted),
    .count_o(d1_count)
  );

  exec_sequencer #(.ADDR_WIDTH(10), .RD_LAT(3)) dut3 (
    .CLK(CLK), .RST(RST), .start_i(s3), .base_addr_i(base3), .len_i(len3), .abort_i(ab3),
    .rd_en_o(d3_rd_en), .rd_addr_o(d3_rd_addr), .wr_en_o(d3_wr_en), .wr_addr_o(d3_wr_addr),
    .sel_mem_o(d3_sel), .busy_o(d3_busy), .done_o(d3_done), .aborted_o(d3_aborted),
    .count_o(d3_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Observed outputs, addresses masked to 0 when their enable is low.
  logic [36:0] obs1, obs3;
  assign obs1 = {d1_rd_en, (d1_rd_en ? d1_rd_addr : 10'h000), d1_wr_en,
                 (d1_wr_en ? d1_wr_addr : 10'h000), d1_busy, d1_sel, d1_done,
                 d1_aborted, d1_count};
  assign obs3 = {d3_rd_en, (d3_rd_en ? d3_rd_addr : 10'h000), d3_wr_en,
                 (d3_wr_en ? d3_wr_addr : 10'h000), d3_busy, d3_sel, d3_done,
                 d3_aborted, d3_count};

  typedef struct {
    logic        start;
    logic        abort;
    logic [9:0]  base;
    logic [10:0] len;
    logic        rd_en;
    logic [9:0]  rd_addr;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [10:0] count;
  } vec_t;

  vec_t tv[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   seen [1024];

  function automatic vec_t v(input logic s, input logic a, input logic [9:0] b,
                             input logic [10:0] l, input logic re, input logic [9:0] ra,
                             input logic we, input logic [9:0] wa, input logic bz,
                             input logic dn, input logic abd, input logic [10:0] cnt);
    vec_t t;
    t.start = s;  t.abort = a;  t.base = b;  t.len = l;
    t.rd_en = re; t.rd_addr = ra; t.wr_en = we; t.wr_addr = wa;
    t.busy = bz;  t.done = dn;  t.aborted = abd; t.count = cnt;
    return t;
  endfunction

  function automatic logic [36:0] exp_of(input vec_t t);
    return {t.rd_en, t.rd_addr, t.wr_en, t.wr_addr, t.busy, t.busy, t.done, t.aborted, t.count};
  endfunction

  function automatic logic [36:0] mk_exp(input logic re, input logic [9:0] ra, input logic we,
                                         input logic [9:0] wa, input logic bz, input logic dn,
                                         input logic abd, input logic [10:0] cnt);
    return {re, ra, we, wa, bz, bz, dn, abd, cnt};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int nrd, dup, bad_wa, last_wr, first_done;

    RST = 1'b0;
    s1 = 1'b0; ab1 = 1'b0; base1 = 10'h000; len1 = 11'd0;
    s3 = 1'b0; ab3 = 1'b0; base3 = 10'h000; len3 = 11'd0;

    // Basic run, base 0x010 len 4
    tv.push_back(v(1'b1, 1'b0, 10'h010, 11'd4, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 11'd0));
    tv.push_back(v(1'b1, 1'b0, 10'h010, 11'd4, 1'b1, 10'h010, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 11'd0));
    tv.push_back(v(1'b1, 1'b0, 10'h010, 11'd4, 1'b1, 10'h011, 1'b1, 10'h010, 1'b1, 1'b0, 1'b0, 11'd0));
    tv.push_back(v(1'b1, 1'b0, 10'h010, 11'd4, 1'b1, 10'h012, 1'b1, 10'h011, 1'b1, 1'b0, 1'b0, 11'd1));
    tv.push_back(v(1'b1, 1'b0, 10'h010, 11'd4, 1'b1, 10'h013, 1'b1, 10'h012, 1'b1, 1'b0, 1'b0, 11'd2));
    tv.push_back(v(1'b1, 1'b0, 10'h010, 11'd4, 1'b0, 10'h000, 1'b1, 10'h013, 1'b1, 1'b0, 1'b0, 11'd3));
    tv.push_back(v(1'b0, 1'b0, 10'h010, 11'd4, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 11'd4));
    tv.push_back(v(1'b0, 1'b0, 10'h010, 11'd4, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 11'd4));
    // Wrap past top address; abort with start in IDLE is ignored
    tv.push_back(v(1'b1, 1'b1, 10'h3FE, 11'd4, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 11'd4));
    tv.push_back(v(1'b1, 1'b0, 10'h3FE, 11'd4, 1'b1, 10'h3FE, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 11'd0));
    tv.push_back(v(1'b1, 1'b0, 10'h3FE, 11'd4, 1'b1, 10'h3FF, 1'b1, 10'h3FE, 1'b1, 1'b0, 1'b0, 11'd0));
    tv.push_back(v(1'b1, 1'b0, 10'h3FE, 11'd4, 1'b1, 10'h000, 1'b1, 10'h3FF, 1'b1, 1'b0, 1'b0, 11'd1));
    tv.push_back(v(1'b1, 1'b0, 10'h3FE, 11'd4, 1'b1, 10'h001, 1'b1, 10'h000, 1'b1, 1'b0, 1'b0, 11'd2));
    tv.push_back(v(1'b1, 1'b0, 10'h3FE, 11'd4, 1'b0, 10'h000, 1'b1, 10'h001, 1'b1, 1'b0, 1'b0, 11'd3));
    tv.push_back(v(1'b0, 1'b0, 10'h3FE, 11'd4, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 11'd4));
    tv.push_back(v(1'b0, 1'b0, 10'h3FE, 11'd4, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 11'd4));
    // Empty window; abort in DONE and IDLE is ignored
    tv.push_back(v(1'b1, 1'b0, 10'h123, 11'd0, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 11'd4));
    tv.push_back(v(1'b1, 1'b0, 10'h123, 11'd0, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 11'd0));
    tv.push_back(v(1'b0, 1'b1, 10'h123, 11'd0, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 11'd0));
    tv.push_back(v(1'b0, 1'b0, 10'h123, 11'd0, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 11'd0));
    tv.push_back(v(1'b0, 1'b1, 10'h123, 11'd0, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 11'd0));
    tv.push_back(v(1'b0, 1'b0, 10'h123, 11'd0, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 11'd0));

    repeat (2) @(posedge CLK);
    #1;
    chk("reset_d1", {27'd0, obs1}, 64'd0);
    chk("reset_d3", {27'd0, obs3}, 64'd0);
    RST = 1'b1;
    step();

    for (int i = 0; i < tv.size(); i++) begin
      s1 = tv[i].start; ab1 = tv[i].abort; base1 = tv[i].base; len1 = tv[i].len;
      chk($sformatf("vec%0d", i), {27'd0, obs1}, {27'd0, exp_of(tv[i])});
      step();
    end
    ab1 = 1'b0;

    // Abort at cycle 20 of a len=100 run
    s1 = 1'b1; base1 = 10'h000; len1 = 11'd100;
    repeat (20) step();
    ab1 = 1'b1;
    chk("abort_c20", {27'd0, obs1},
        {27'd0, mk_exp(1'b1, 10'd19, 1'b1, 10'd18, 1'b1, 1'b0, 1'b0, 11'd18)});
    step();
    ab1 = 1'b0;
    for (int c = 21; c < 26; c++) begin
      chk($sformatf("abort_c%0d", c), {27'd0, obs1},
          {27'd0, mk_exp(1'b0, 10'd0, 1'b0, 10'd0, 1'b0, 1'b1, 1'b1, 11'd19)});
      step();
    end
    s1 = 1'b0;
    step();
    chk("abort_release", {63'd0, d1_done}, 64'd0);

    // Full sweep on RD_LAT=3 instance
    nrd = 0; dup = 0; bad_wa = 0; last_wr = 0; first_done = 0;
    s3 = 1'b1; base3 = 10'h000; len3 = 11'd1024;
    for (int c = 1; c <= 1030; c++) begin
      step();
      if (d3_rd_en) begin
        nrd++;
        if (seen[d3_rd_addr]) dup++;
        seen[d3_rd_addr] = 1'b1;
      end
      if (d3_wr_en) begin
        last_wr = c;
        if (d3_wr_addr !== 10'(c - 4)) bad_wa++;
      end
      if (d3_done && (first_done == 0)) first_done = c;
    end
    chk("sweep_reads", 64'(nrd), 64'd1024);
    chk("sweep_dups", 64'(dup), 64'd0);
    chk("sweep_wr_addr_errs", 64'(bad_wa), 64'd0);
    chk("sweep_last_wr_cycle", 64'(last_wr), 64'd1027);
    chk("sweep_done_cycle", 64'(first_done), 64'd1028);
    chk("sweep_count", {53'd0, d3_count}, 64'd1024);
    s3 = 1'b0;
    step();

    // Reset mid-run, then a short clean run
    s1 = 1'b1; base1 = 10'h000; len1 = 11'd50;
    repeat (10) step();
    #2 RST = 1'b0;
    #1 chk("rst_async", {27'd0, obs1}, 64'd0);
    @(posedge CLK);
    #1;
    chk("rst_hold", {27'd0, obs1}, 64'd0);
    s1 = 1'b0;
    RST = 1'b1;
    step();
    s1 = 1'b1; base1 = 10'h005; len1 = 11'd2;
    step();
    chk("post_rst_c1", {27'd0, obs1},
        {27'd0, mk_exp(1'b1, 10'h005, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 11'd0)});
    step();
    chk("post_rst_c2", {27'd0, obs1},
        {27'd0, mk_exp(1'b1, 10'h006, 1'b1, 10'h005, 1'b1, 1'b0, 1'b0, 11'd0)});
    step();
    chk("post_rst_c3", {27'd0, obs1},
        {27'd0, mk_exp(1'b0, 10'h000, 1'b1, 10'h006, 1'b1, 1'b0, 1'b0, 11'd1)});
    step();
    chk("post_rst_c4", {27'd0, obs1},
        {27'd0, mk_exp(1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 11'd2)});
    s1 = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
